ternary_weight_loader: RTL and testbench



---
 rtl/ternary_weight_loader.sv | 208 ++++++++++++++++++++
 tb/tb_ternary_weight_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_weight_loader.sv
// ternary_weight_loader
//
// Streams a ternary weight matrix in over a valid/ready beat interface into a
// staging buffer, then publishes the completed matrix on a flat weight bus in
// a single cycle. This keeps the published weights stable for the whole of the
// next load. A start during a load aborts it and begins again from beat 0.
//
// Optional build macro:
//   WEIGHT_CHECK_EN - checks each accepted WIDTH-bit field for the reserved
//                     code (MSB set, rest clear; 2'b10 for WIDTH=2). Any such
//                     field is stored as zero and sets the sticky err flag.
//                     When the macro is undefined, beats are stored verbatim
//                     and err is tied low.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   ena           block enable; low freezes all state
//   start         begin or restart a matrix load
//   in_data       weight beat; lowest weight in the lowest bits
//   in_valid      beat present
//   in_ready      loader accepts a beat this cycle
//   uo_weights    published matrix; weight k=row*MAX_IN_LEN+col at [k*WIDTH +: WIDTH]
//   uo_done       one-cycle pulse in the publish cycle
//   busy          load in progress
//   weights_valid sticky; at least one matrix has been published
//   err           sticky reserved-code flag (WEIGHT_CHECK_EN only)

module ternary_weight_loader #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int WIDTH       = 2,
  parameter int IN_W        = 8,
  localparam int TOTAL      = WIDTH * MAX_IN_LEN * MAX_OUT_LEN,
  localparam int BEATS      = TOTAL / IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [TOTAL-1:0] uo_weights,
  output logic             uo_done,
  output logic             busy,
  output logic             weights_valid,
  output logic             err
);

  localparam int FIELDS = IN_W / WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   beat_cnt_reg;
  logic [TOTAL-1:0]   staging_reg;
  logic [TOTAL-1:0]   weights_reg;
  logic               weights_valid_reg;

  logic [IN_W-1:0]    beat_clean;
  logic [TOTAL-1:0]   publish_flat;
  logic               accept;
  logic               restart;
  logic               last_beat;

  // ---------------------------------------------------------------------------
  // Beat sanitising
  // ---------------------------------------------------------------------------
`ifdef WEIGHT_CHECK_EN
  localparam logic [WIDTH-1:0] RESERVED = {1'b1, {(WIDTH-1){1'b0}}};

  logic [FIELDS-1:0] field_bad;
  logic              err_reg;

  generate
    for (genvar gi = 0; gi < FIELDS; gi++) begin : g_field_check
      assign field_bad[gi] = (in_data[gi*WIDTH +: WIDTH] == RESERVED);
      assign beat_clean[gi*WIDTH +: WIDTH] =
        field_bad[gi] ? '0 : in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign err = err_reg;
`else
  assign beat_clean = in_data;
  assign err        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Matrix to publish: staging with the terminal beat merged in, so the bus
  // updates at the same edge that accepts the last beat.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_publish
      if (gi == BEATS - 1) begin : g_last
        assign publish_flat[gi*IN_W +: IN_W] = beat_clean;
      end else begin : g_body
        assign publish_flat[gi*IN_W +: IN_W] = staging_reg[gi*IN_W +: IN_W];
      end
    end
  endgenerate

  // A start in LOAD wins over a coincident beat: the beat is dropped.
  assign restart   = (state_reg == LOAD) && ena && start;
  assign accept    = in_valid && in_ready && !start;
  assign last_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else if (ena) begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        if (start)                       state_next = LOAD;
        else if (accept && last_beat)    state_next = PUBLISH;
      end
      PUBLISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. uo_done is held back while ena is low; the PUBLISH state
  // persists until ena returns, so the pulse is deferred rather than lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    uo_done  = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = ena;
        busy     = 1'b1;
      end
      PUBLISH: begin
        uo_done = ena;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: beat counter, staging buffer, published weights, flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg      <= '0;
      staging_reg       <= '0;
      weights_reg       <= '0;
      weights_valid_reg <= 1'b0;
`ifdef WEIGHT_CHECK_EN
      err_reg           <= 1'b0;
`endif
    end else if (ena) begin
      if (state_reg == IDLE && start) begin
        beat_cnt_reg <= '0;
`ifdef WEIGHT_CHECK_EN
        err_reg      <= 1'b0;
`endif
      end

      if (restart) begin
        // Old staging contents are simply overwritten by the new load.
        beat_cnt_reg <= '0;
      end else if (accept) begin
        staging_reg[beat_cnt_reg*IN_W +: IN_W] <= beat_clean;
`ifdef WEIGHT_CHECK_EN
        if (|field_bad) err_reg <= 1'b1;
`endif
        if (last_beat) begin
          beat_cnt_reg      <= '0;
          weights_reg       <= publish_flat;
          weights_valid_reg <= 1'b1;
        end else begin
          beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign uo_weights    = weights_reg;
  assign weights_valid = weights_valid_reg;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Directed testbench for ternary_weight_loader (default parameters:
// 16x8 matrix of 2-bit weights, 8-bit beats, 32 beats per matrix).
// Prints one line per published matrix and one summary line.

module tb_ternary_weight_loader;

  localparam int IN_W  = 8;
  localparam int TOTAL = 256;
  localparam int BEATS = 32;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             start;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [TOTAL-1:0] uo_weights;
  logic             uo_done;
  logic             busy;
  logic             weights_valid;
  logic             err;

  int checks;
  int errors;
  int done_cnt;

  logic [IN_W-1:0]  beat_mem [BEATS];
  logic [TOTAL-1:0] exp_w;
  logic [TOTAL-1:0] mat_a;

  ternary_weight_loader dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .uo_weights   (uo_weights),
    .uo_done      (uo_done),
    .busy         (busy),
    .weights_valid(weights_valid),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One line per published matrix.
  always @(negedge clk) begin
    if (uo_done) begin
      done_cnt++;
      $display("publish %0d: weights[63:0]=%h valid=%b err=%b",
               done_cnt, uo_weights[63:0], weights_valid, err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Byte made only of legal ternary codes (00, 01, 11), varying with i.
  function automatic logic [7:0] pat_byte(input int i);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 4; j++) begin
      case ((i + j) % 3)
        0:       b[j*2 +: 2] = 2'b00;
        1:       b[j*2 +: 2] = 2'b01;
        default: b[j*2 +: 2] = 2'b11;
      endcase
    end
    return b;
  endfunction

  function automatic logic [TOTAL-1:0] mem_matrix();
    logic [TOTAL-1:0] m;
    for (int i = 0; i < BEATS; i++) m[i*IN_W +: IN_W] = beat_mem[i];
    return m;
  endfunction

  // Sends n beats from beat_mem[0..]. With gaps set, in_valid drops every
  // fourth cycle and ena is held low for 3 cycles once 15 beats are in.
  // Returns with the clock just past the edge that accepted the last beat.
  task automatic send_stream(input int n, input bit gaps, output int cycles);
    int  acc;
    bit  took;
    bit  stalled;
    acc     = 0;
    cycles  = 0;
    stalled = 1'b0;
    while (acc < n && cycles < 400) begin
      if (gaps && !stalled && acc == 15) begin
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = beat_mem[acc];
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %b expected 0", in_ready);
          end
        end
        ena     = 1'b1;
        stalled = 1'b1;
      end
      in_valid = !(gaps && (cycles % 4 == 1));
      in_data  = beat_mem[acc];
      #1;
      took = in_valid && in_ready;
      tick();
      cycles++;
      if (took) acc++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc != n) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d expected %0d", acc, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (uo_weights !== '0)     begin errors++; $display("FAIL reset_weights: got %h expected 0", uo_weights); end
    checks++; if (uo_done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", uo_done); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", weights_valid); end
    checks++; if (err !== 1'b0)          begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5D;
    repeat (5) tick();
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL idle_in_ready: got %b expected 0", in_ready); end
    checks++; if (uo_weights !== '0)   begin errors++; $display("FAIL idle_weights: got %h expected 0", uo_weights); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    int cyc;
    int d0;
    for (int i = 0; i < BEATS; i++) beat_mem[i] = 8'h5D;
    exp_w = {32{8'h5D}};
    d0 = done_cnt;
    do_start();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    send_stream(BEATS, 1'b0, cyc);
    checks++; if (cyc != BEATS)            begin errors++; $display("FAIL full_cycles: got %0d expected %0d", cyc, BEATS); end
    checks++; if (uo_done !== 1'b1)        begin errors++; $display("FAIL full_done: got %b expected 1", uo_done); end
    checks++; if (uo_weights !== exp_w)    begin errors++; $display("FAIL full_weights: got %h expected %h", uo_weights, exp_w); end
    checks++; if (weights_valid !== 1'b1)  begin errors++; $display("FAIL full_valid: got %b expected 1", weights_valid); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL full_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b0)       begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    tick();
    checks++; if (uo_done !== 1'b0)        begin errors++; $display("FAIL full_done_drop: got %b expected 0", uo_done); end
    checks++; if (done_cnt - d0 != 1)      begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_stall();
    int cyc;
    for (int i = 0; i < BEATS; i++) beat_mem[i] = pat_byte(i);
    exp_w = mem_matrix();
    do_start();
    send_stream(BEATS, 1'b1, cyc);
    checks++; if (uo_done !== 1'b1)     begin errors++; $display("FAIL stall_done: got %b expected 1", uo_done); end
    checks++; if (uo_weights !== exp_w) begin errors++; $display("FAIL stall_weights: got %h expected %h", uo_weights, exp_w); end
    tick();
  endtask

  task automatic test_abort();
    int cyc;
    for (int i = 0; i < BEATS; i++) beat_mem[i] = 8'h55;
    mat_a = {32{8'h55}};
    do_start();
    send_stream(BEATS, 1'b0, cyc);
    tick();
    checks++; if (uo_weights !== mat_a) begin errors++; $display("FAIL abort_a: got %h expected %h", uo_weights, mat_a); end
    for (int i = 0; i < BEATS; i++) beat_mem[i] = 8'hFF;
    do_start();
    send_stream(10, 1'b0, cyc);
    checks++; if (uo_weights !== mat_a) begin errors++; $display("FAIL abort_partial: got %h expected %h", uo_weights, mat_a); end
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL abort_busy: got %b expected 1", busy); end
    // Restart coinciding with a valid beat: the beat must be dropped.
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < BEATS; i++) beat_mem[i] = 8'h00;
    send_stream(BEATS - 1, 1'b0, cyc);
    checks++; if (uo_weights !== mat_a) begin errors++; $display("FAIL abort_hold: got %h expected %h", uo_weights, mat_a); end
    checks++; if (uo_done !== 1'b0)     begin errors++; $display("FAIL abort_early_done: got %b expected 0", uo_done); end
    send_stream(1, 1'b0, cyc);
    checks++; if (uo_done !== 1'b1)     begin errors++; $display("FAIL abort_done: got %b expected 1", uo_done); end
    checks++; if (uo_weights !== '0)    begin errors++; $display("FAIL abort_new: got %h expected 0", uo_weights); end
    tick();
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    int d0;
    for (int i = 0; i < BEATS; i++) beat_mem[i] = 8'h5D;
    do_start();
    send_stream(BEATS, 1'b0, cyc);
    tick();
    do_start();
    send_stream(20, 1'b0, cyc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d0 = done_cnt;
    checks++; if (uo_weights !== '0)     begin errors++; $display("FAIL rst_mid_weights: got %h expected 0", uo_weights); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", weights_valid); end
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h5D;
    repeat (40) tick();
    in_valid = 1'b0;
    checks++; if (done_cnt != d0)        begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - d0); end
  endtask

  task automatic test_weight_check();
    int cyc;
    logic exp_err;
    for (int i = 0; i < BEATS; i++) beat_mem[i] = 8'h55;
    beat_mem[5] = 8'h86;
    exp_w = {32{8'h55}};
`ifdef WEIGHT_CHECK_EN
    exp_w[5*8 +: 8] = 8'h04;
    exp_err = 1'b1;
`else
    exp_w[5*8 +: 8] = 8'h86;
    exp_err = 1'b0;
`endif
    do_start();
    send_stream(BEATS, 1'b0, cyc);
    checks++; if (uo_weights !== exp_w) begin errors++; $display("FAIL check_weights: got %h expected %h", uo_weights, exp_w); end
    checks++; if (err !== exp_err)      begin errors++; $display("FAIL check_err: got %b expected %b", err, exp_err); end
    checks++; if (uo_done !== 1'b1)     begin errors++; $display("FAIL check_done: got %b expected 1", uo_done); end
    // Start during the publish cycle is ignored.
    start = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL publish_start_in_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL publish_start_busy: got %b expected 0", busy); end
    checks++; if (err !== exp_err)      begin errors++; $display("FAIL check_err_sticky: got %b expected %b", err, exp_err); end
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL restart_in_ready: got %b expected 1", in_ready); end
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL check_err_clear: got %b expected 0", err); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    ena      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_full_load();
    test_stall();
    test_abort();
    test_reset_mid_load();
    test_weight_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
